// File: rtl/event_header_builder.sv
// event_header_builder: queues trigger snapshots, issues SURF commands per event
// and writes a 9-word header per event into the buffer-indexed header RAM.
module event_header_builder #(
    parameter int NBUF       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DUAL       = 1,
    parameter int GAP        = 2,
    localparam int BB        = $clog2(NBUF)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          digitize_i,
    input  logic [BB-1:0] digitize_buffer_i,
    input  logic [3:0]    source_i,
    input  logic [31:0]   pattern_i,
    input  logic [15:0]   pps_time_i,
    input  logic [31:0]   clock_time_i,
    input  logic [11:0]   epoch_i,
    input  logic          evid_reset_i,
    output logic          cmd_start_o,
    output logic [31:0]   cmd_event_id_o,
    output logic [BB-1:0] cmd_buffer_o,
    input  logic          cmd_busy_i,
    input  logic          cmd_done_i,
    output logic [BB+3:0] event_addr_o,
    output logic [15:0]   event_dat_o,
    output logic          event_wr_o,
    output logic          event_done_o,
    output logic [31:0]   next_id_o,
    output logic          overflow_o,
    output logic          pending_o
);
    localparam int SW = BB + 84;
    localparam int FB = $clog2(FIFO_DEPTH);
    localparam logic [FB:0] DEPTH = (FB+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, CMD_WAIT, CMD1, GAP_S, CMD2, WRITE, DONE} state_t;
    state_t state, nxt;

    logic          dig_q, dig_d, rise, snap_v;
    logic [SW-1:0] snap, head;
    logic [SW-1:0] mem [FIFO_DEPTH];
    logic [FB:0]   wr_ptr, rd_ptr, count;
    logic          full, push, pop;
    logic [3:0]    gap_cnt, word;
    logic [15:0]   event_count;
    logic [31:0]   id;
    logic [BB-1:0] h_buf;
    logic [3:0]    h_src;
    logic [31:0]   h_pat, h_clk;
    logic [15:0]   h_pps, dat;

    assign rise = dig_q & ~dig_d;

    // Snapshot is taken on the edge cycle and pushed the cycle after.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dig_q  <= 1'b0;
            dig_d  <= 1'b0;
            snap_v <= 1'b0;
            snap   <= '0;
        end else begin
            dig_q  <= digitize_i;
            dig_d  <= dig_q;
            snap_v <= rise;
            if (rise)
                snap <= {digitize_buffer_i, source_i, pattern_i, pps_time_i, clock_time_i};
        end
    end

    assign count     = wr_ptr - rd_ptr;
    assign full      = count == DEPTH;
    assign pending_o = count != '0;
    assign pop       = state == DONE;
    assign push      = snap_v & (~full | pop);

    always_ff @(posedge clk_i)
        if (push)
            mem[wr_ptr[FB-1:0]] <= snap;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (snap_v & full & ~pop)
                overflow_o <= 1'b1;
        end
    end

    assign head  = mem[rd_ptr[FB-1:0]];
    assign h_buf = head[SW-1 -: BB];
    assign h_src = head[83:80];
    assign h_pat = head[79:48];
    assign h_pps = head[47:32];
    assign h_clk = head[31:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            gap_cnt <= '0;
            word    <= '0;
        end else begin
            state   <= nxt;
            gap_cnt <= (state == GAP_S) ? gap_cnt + 4'd1 : 4'd0;
            word    <= (state == WRITE) ? word + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        nxt         = state;
        cmd_start_o = 1'b0;
        case (state)
            IDLE:     nxt = pending_o ? CMD_WAIT : IDLE;
            CMD_WAIT: if (!cmd_busy_i) begin
                          cmd_start_o = 1'b1;
                          nxt         = CMD1;
                      end
            CMD1:     if (cmd_done_i)
                          nxt = (DUAL != 0) ? GAP_S : WRITE;
            GAP_S:    if (gap_cnt == 4'(GAP)) begin
                          cmd_start_o = 1'b1;
                          nxt         = CMD2;
                      end
            CMD2:     nxt = cmd_done_i ? WRITE : CMD2;
            WRITE:    nxt = (word == 4'd8) ? DONE : WRITE;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            event_count <= '0;
            id          <= '0;
        end else begin
            if (pop)
                event_count <= event_count + 16'd1;
            if (evid_reset_i)
                id <= {epoch_i, 20'h0};
            else if (pop)
                id <= {epoch_i, id[19:0] + 20'd1};
        end
    end

    always_comb begin
        dat = 16'h0;
        case (word)
            4'd0: dat = {8'h00, h_src, 4'(h_buf)};
            4'd1: dat = event_count;
            4'd2: dat = h_clk[15:0];
            4'd3: dat = h_clk[31:16];
            4'd4: dat = h_pps;
            4'd5: dat = h_pat[15:0];
            4'd6: dat = h_pat[31:16];
            4'd7: dat = id[15:0];
            4'd8: dat = id[31:16];
            default: dat = 16'h0;
        endcase
    end

    // The second command of a dual event targets the partner buffer.
    assign cmd_buffer_o   = (state == IDLE) ? '0 :
                            (state == GAP_S || state == CMD2) ? h_buf ^ BB'(1) : h_buf;
    assign cmd_event_id_o = id;
    assign next_id_o      = id;
    assign event_wr_o     = state == WRITE;
    assign event_addr_o   = event_wr_o ? {h_buf, word} : '0;
    assign event_dat_o    = event_wr_o ? dat : 16'h0;
    assign event_done_o   = state == DONE;
endmodule

// File: tb/tb_event_header_builder.sv
// tb_event_header_builder: directed checks of command sequencing, header contents,
// overflow, event-ID handling and mid-event reset; a DUAL=0 copy counts commands.
module tb_event_header_builder;
    logic        clk = 1'b0, rst = 1'b1;
    logic        digitize = 1'b0, evid_reset = 1'b0, busy = 1'b0, spur = 1'b0;
    logic [1:0]  dbuf = '0;
    logic [3:0]  source = '0;
    logic [31:0] pattern = '0, clock_time = '0;
    logic [15:0] pps = '0;
    logic [11:0] epoch = '0;
    logic        resp_a = 1'b0, resp_b = 1'b0;

    logic        cmd_start, event_wr, event_done, overflow, pending;
    logic [31:0] cmd_event_id, next_id;
    logic [1:0]  cmd_buffer;
    logic [5:0]  event_addr;
    logic [15:0] event_dat;

    logic        cmd_start_b, event_wr_b, event_done_b, overflow_b, pending_b;
    logic [31:0] cmd_event_id_b, next_id_b;
    logic [1:0]  cmd_buffer_b;
    logic [5:0]  event_addr_b;
    logic [15:0] event_dat_b;

    int total = 0, bad = 0, cyc = 0;
    int ns, nw, dn, nd, nsb, dnb, ca = 0, cb = 0;
    int st_cyc [64];
    int dcyc [64];
    logic [1:0]  st_buf [64];
    logic [31:0] st_id [64];
    logic [5:0]  wa [64];
    logic [15:0] wd [64];
    logic [1:0]  bl [5] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    event_header_builder #(.NBUF(4), .FIFO_DEPTH(4), .DUAL(1), .GAP(2)) dut (
        .clk_i(clk), .rst_i(rst), .digitize_i(digitize), .digitize_buffer_i(dbuf),
        .source_i(source), .pattern_i(pattern), .pps_time_i(pps), .clock_time_i(clock_time),
        .epoch_i(epoch), .evid_reset_i(evid_reset), .cmd_start_o(cmd_start),
        .cmd_event_id_o(cmd_event_id), .cmd_buffer_o(cmd_buffer), .cmd_busy_i(busy),
        .cmd_done_i(resp_a | spur), .event_addr_o(event_addr), .event_dat_o(event_dat),
        .event_wr_o(event_wr), .event_done_o(event_done), .next_id_o(next_id),
        .overflow_o(overflow), .pending_o(pending));

    event_header_builder #(.NBUF(4), .FIFO_DEPTH(4), .DUAL(0), .GAP(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .digitize_i(digitize), .digitize_buffer_i(dbuf),
        .source_i(source), .pattern_i(pattern), .pps_time_i(pps), .clock_time_i(clock_time),
        .epoch_i(epoch), .evid_reset_i(evid_reset), .cmd_start_o(cmd_start_b),
        .cmd_event_id_o(cmd_event_id_b), .cmd_buffer_o(cmd_buffer_b), .cmd_busy_i(busy),
        .cmd_done_i(resp_b), .event_addr_o(event_addr_b), .event_dat_o(event_dat_b),
        .event_wr_o(event_wr_b), .event_done_o(event_done_b), .next_id_o(next_id_b),
        .overflow_o(overflow_b), .pending_o(pending_b));

    // Monitor plus SURF model: cmd_done pulses five cycles after each start.
    always @(negedge clk) begin
        if (cmd_start) begin
            if (ns < 64) begin
                st_cyc[ns] = cyc;
                st_buf[ns] = cmd_buffer;
                st_id[ns]  = cmd_event_id;
            end
            ns++;
        end
        if (event_wr) begin
            if (nw < 64) begin
                wa[nw] = event_addr;
                wd[nw] = event_dat;
            end
            nw++;
        end
        if (event_done) dn++;
        if (cmd_start_b) nsb++;
        if (event_done_b) dnb++;
        resp_a = 1'b0;
        resp_b = 1'b0;
        if (rst) begin
            ca = 0;
            cb = 0;
        end else begin
            if (cmd_start) ca = 5;
            else if (ca != 0) begin
                ca--;
                if (ca == 0) begin
                    resp_a = 1'b1;
                    if (nd < 64) dcyc[nd] = cyc;
                    nd++;
                end
            end
            if (cmd_start_b) cb = 5;
            else if (cb != 0) begin
                cb--;
                if (cb == 0) resp_b = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        ns = 0; nw = 0; dn = 0; nd = 0; nsb = 0; dnb = 0;
    endtask

    task automatic trig(input logic [1:0] b);
        @(negedge clk);
        dbuf = b;
        digitize = 1'b1;
        repeat (2) @(negedge clk);
        digitize = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_dones(input int target);
        for (int i = 0; i < 600 && dn < target; i++) @(negedge clk);
        check("done_count", dn, target);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        clear_log();
        repeat (3) @(negedge clk);
        check("rst_start", cmd_start, 0);
        check("rst_wr", event_wr, 0);
        check("rst_done", event_done, 0);
        check("rst_id", next_id, 0);
        check("rst_ovf", overflow, 0);
        check("rst_pend", pending, 0);
        check("rst_bus", {cmd_buffer, event_addr, event_dat, cmd_event_id[7:0]}, 0);
        rst = 1'b0;

        // single dual-command event
        source = 4'hA; pattern = 32'hDEADBEEF; pps = 16'h1234; clock_time = 32'h89ABCDEF;
        trig(2'd2);
        wait_dones(1);
        check("t1_nstart", ns, 2);
        check("t1_buf0", st_buf[0], 2);
        check("t1_buf1", st_buf[1], 3);
        check("t1_gap", st_cyc[1] - dcyc[0], 3);
        check("t1_id0", st_id[0], 0);
        check("t1_nwr", nw, 9);
        for (int i = 0; i < 9; i++) check("t1_addr", wa[i], 32'h20 + i);
        check("t1_w0", wd[0], 16'h00A2);
        check("t1_w1", wd[1], 16'h0000);
        check("t1_w2", wd[2], 16'hCDEF);
        check("t1_w3", wd[3], 16'h89AB);
        check("t1_w4", wd[4], 16'h1234);
        check("t1_w5", wd[5], 16'hBEEF);
        check("t1_w6", wd[6], 16'hDEAD);
        check("t1_w7", wd[7], 16'h0000);
        check("t1_w8", wd[8], 16'h0000);
        check("t1_nextid", next_id, 32'h1);
        check("single_nstart", nsb, 1);
        check("single_ndone", dnb, 1);

        // five triggers while the command interface is busy
        do_reset();
        clear_log();
        busy = 1'b1;
        for (int k = 0; k < 5; k++) trig(bl[k]);
        @(negedge clk);
        check("t2_ovf", overflow, 1);
        check("t2_pend", pending, 1);
        check("t2_nstart", ns, 0);
        busy = 1'b0;
        wait_dones(4);
        check("t2_nwr", nw, 36);
        for (int k = 0; k < 4; k++) begin
            check("t2_addr", wa[9*k], {26'd0, bl[k], 4'd0});
            check("t2_count", wd[9*k+1], k);
            check("t2_idlo", wd[9*k+7], k);
        end
        check("t2_nextid", next_id, 32'h4);
        check("t2_ovf_sticky", overflow, 1);
        check("t2_pend_empty", pending, 0);

        // stray cmd_done in IDLE, then epoch takes over the ID high bits
        epoch = 12'h123;
        @(negedge clk); spur = 1'b1;
        @(negedge clk); spur = 1'b0;
        clear_log();
        trig(2'd1);
        wait_dones(1);
        check("t3_nstart", ns, 2);
        check("t3_idlo", wd[7], 16'h0004);
        check("t3_idhi", wd[8], 16'h0000);
        check("t3_count", wd[1], 16'h0004);
        check("t3_nextid", next_id, 32'h12300005);

        // event-ID reset in the DONE cycle beats the increment
        trig(2'd0);
        for (int i = 0; i < 200 && !event_done; i++) @(negedge clk);
        check("t4_seen_done", event_done, 1);
        evid_reset = 1'b1;
        epoch = 12'h005;
        @(negedge clk);
        evid_reset = 1'b0;
        check("t4_nextid", next_id, 32'h00500000);

        // reset during word 4 of the header write
        trig(2'd2);
        for (int i = 0; i < 200 && !(event_wr && event_addr[3:0] == 4'd4); i++) @(negedge clk);
        check("t5_at_w4", {event_wr, event_addr}, {1'b1, 6'h24});
        rst = 1'b1;
        #1;
        check("t5_wr_off", event_wr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        trig(2'd2);
        trig(2'd1);
        wait_dones(2);
        check("t5_nwr", nw, 18);
        for (int i = 0; i < 9; i++) check("t5_addr", wa[i], 32'h20 + i);
        check("t5_count0", wd[1], 16'h0000);
        check("t5_count1", wd[10], 16'h0001);
        check("t5_addr2", wa[9], 32'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
